pattern_gen: RTL and testbench

- Parametrised test-pattern generator for the HDMI output path; successor to the fixed 1280x720 info/test-pattern renderer.
- Takes pixel coordinates and data-enable from the video timing generator and produces registered RGB with a matched, delayed data-enable.
- Adds resolution, colour-depth and pattern-size parameters, a frame counter, frame-synchronous mode switching and an animated bouncing box.
- Feeds the overlay mixer; sits beside the slots screensaver.

---
 rtl/pattern_gen.sv | 190 +++++++++++++++++++
 tb/tb_pattern_gen.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Parametrised HDMI test-pattern generator: two-stage registered RGB with aligned
// data-enable, frame counter, frame-synchronous mode switching and a bouncing box.
module pattern_gen #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int COORD_W    = 12,
    parameter int COLOR_W    = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int GRID_LOG2  = 6,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_SPEED  = 4,
    parameter int FRAME_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic [COORD_W-1:0]     px,
    input  logic [COORD_W-1:0]     py,
    input  logic                   de,
    input  logic [2:0]             mode,
    input  logic [3*COLOR_W-1:0]   solid_color,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   de_out,
    output logic [2:0]             mode_active,
    output logic [FRAME_W-1:0]     frame_cnt
);
    localparam int XW = COORD_W + 1;
    localparam logic [XW-1:0] H_LIM = XW'(H_ACTIVE);
    localparam logic [XW-1:0] V_LIM = XW'(V_ACTIVE);
    localparam logic [XW-1:0] H_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] V_LAST = XW'(V_ACTIVE - 1);
    localparam logic [XW-1:0] XMAX = XW'(H_ACTIVE - BOX_SIZE);
    localparam logic [XW-1:0] YMAX = XW'(V_ACTIVE - BOX_SIZE);
    localparam logic [XW-1:0] SPEED = XW'(BOX_SPEED);
    localparam logic [XW-1:0] BOX_W = XW'(BOX_SIZE);
    localparam logic [COLOR_W-1:0] MAX = {COLOR_W{1'b1}};
    localparam logic [COLOR_W-1:0] GREY = MAX >> 3;

    logic [XW-1:0]      box_x, box_y;
    logic               dir_x, dir_y;
    logic [XW-1:0]      px_e, py_e;
    logic [2:0]         bar;
    logic [2:0]         bar_on;
    logic               in_box;
    logic               fc_b5;
    logic [COLOR_W-1:0] fc_lo;
    logic [COLOR_W-1:0] r_c, g_c, b_c;
    logic [COLOR_W-1:0] r_p0, g_p0, b_p0;
    logic               vld_p0;

    // One bounce step along an axis; returns {forward, position}.
    function automatic logic [XW:0] box_step(input logic [XW-1:0] pos, input logic fwd,
                                             input logic [XW-1:0] lim);
        logic [XW:0] res;
        if (fwd) begin
            if (pos + SPEED >= lim) res = {1'b0, lim};
            else                    res = {1'b1, pos + SPEED};
        end else begin
            if (pos <= SPEED) res = {1'b1, {XW{1'b0}}};
            else              res = {1'b0, pos - SPEED};
        end
        return res;
    endfunction

    // Bar index to {r,g,b} on/off: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] k);
        logic [2:0] c;
        case (k)
            3'd0:    c = 3'b111;
            3'd1:    c = 3'b110;
            3'd2:    c = 3'b011;
            3'd3:    c = 3'b010;
            3'd4:    c = 3'b101;
            3'd5:    c = 3'b100;
            3'd6:    c = 3'b001;
            default: c = 3'b000;
        endcase
        return c;
    endfunction

    function automatic logic [COLOR_W-1:0] full(input logic on);
        return on ? MAX : {COLOR_W{1'b0}};
    endfunction

    if (FRAME_W > 5) begin : g_fc_b5
        assign fc_b5 = frame_cnt[5];
    end else begin : g_fc_b5_zero
        assign fc_b5 = 1'b0;
    end

    if (FRAME_W >= COLOR_W) begin : g_fc_lo
        assign fc_lo = frame_cnt[COLOR_W-1:0];
    end else begin : g_fc_lo_ext
        assign fc_lo = {{(COLOR_W-FRAME_W){1'b0}}, frame_cnt};
    end

    assign px_e = {1'b0, px};
    assign py_e = {1'b0, py};
    assign in_box = (px_e >= box_x) && (px_e < box_x + BOX_W) &&
                    (py_e >= box_y) && (py_e < box_y + BOX_W);

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (px_e >= XW'((k * H_ACTIVE) / 8)) bar = 3'(k);
        end
        bar_on = bar_rgb(bar);
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (mode_active)
            3'd0: {b_c, g_c, r_c} = solid_color;
            3'd1: begin
                r_c = full(bar_on[2]);
                g_c = full(bar_on[1]);
                b_c = full(bar_on[0]);
            end
            3'd2: begin
                r_c = px[COLOR_W-1:0];
                g_c = px[COLOR_W-1:0];
                b_c = px[COLOR_W-1:0];
            end
            3'd3: begin
                r_c = full(px[CHECK_LOG2] ^ py[CHECK_LOG2] ^ fc_b5);
                g_c = r_c;
                b_c = r_c;
            end
            3'd4: begin
                r_c = in_box ? MAX : GREY;
                g_c = r_c;
                b_c = r_c;
            end
            3'd5: begin
                r_c = full((px[GRID_LOG2-1:0] == '0) || (py[GRID_LOG2-1:0] == '0) ||
                           (px_e == H_LAST) || (py_e == V_LAST));
                g_c = r_c;
                b_c = r_c;
            end
            3'd6: begin
                r_c = px[COLOR_W-1:0] + fc_lo;
                g_c = py[COLOR_W-1:0] + fc_lo;
                b_c = px[COLOR_W-1:0] ^ py[COLOR_W-1:0];
            end
            default: ;
        endcase
        if (!de || px_e >= H_LIM || py_e >= V_LIM) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_active <= '0;
            frame_cnt   <= '0;
            box_x       <= '0;
            box_y       <= '0;
            dir_x       <= 1'b1;
            dir_y       <= 1'b1;
            r_p0        <= '0;
            g_p0        <= '0;
            b_p0        <= '0;
            vld_p0      <= 1'b0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de_out      <= 1'b0;
        end else begin
            if (frame_start) begin
                mode_active    <= mode;
                frame_cnt      <= frame_cnt + 1'b1;
                {dir_x, box_x} <= box_step(box_x, dir_x, XMAX);
                {dir_y, box_y} <= box_step(box_y, dir_y, YMAX);
            end
            // stage p0: pattern colour for the incoming pixel
            r_p0   <= r_c;
            g_p0   <= g_c;
            b_p0   <= b_c;
            vld_p0 <= de;
            // stage p1: output register
            r      <= r_p0;
            g      <= g_p0;
            b      <= b_p0;
            de_out <= vld_p0;
        end
    end
endmodule

// File: tb/tb_pattern_gen.sv
// Bench for pattern_gen: constant vector table, hand sequences for frame-level
// behaviour, and random stimulus checked against a frame-count based reference.
module tb_pattern_gen;
    localparam int H = 1280;
    localparam int V = 720;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic        de = 1'b0;
    logic [11:0] px = '0;
    logic [11:0] py = '0;
    logic [2:0]  mode = '0;
    logic [23:0] solid_color = '0;
    logic [7:0]  r, g, b;
    logic        de_out;
    logic [2:0]  mode_active;
    logic [15:0] frame_cnt;
    logic [7:0]  r4, g4, b4;
    logic        de_out4;
    logic [2:0]  mode_active4;
    logic [3:0]  frame_cnt4;

    int n_cmp = 0;
    int n_fail = 0;
    int m_mode = 0;
    int m_n = 0;
    logic [24:0] exp_d1 = '0;
    logic [24:0] exp_d2 = '0;

    pattern_gen dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .px(px), .py(py), .de(de),
        .mode(mode), .solid_color(solid_color), .r(r), .g(g), .b(b), .de_out(de_out),
        .mode_active(mode_active), .frame_cnt(frame_cnt)
    );

    pattern_gen #(.FRAME_W(4)) dut4 (
        .clk(clk), .rst(rst), .frame_start(frame_start), .px(px), .py(py), .de(de),
        .mode(mode), .solid_color(solid_color), .r(r4), .g(g4), .b(b4), .de_out(de_out4),
        .mode_active(mode_active4), .frame_cnt(frame_cnt4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    // Box position after n frame updates: triangle wave between 0 and lim.
    function automatic int tri_pos(input int n, input int lim);
        int t;
        t = (n * 4) % (2 * lim);
        return (t <= lim) ? t : 2 * lim - t;
    endfunction

    function automatic logic [23:0] model_rgb(input int md, input int x, input int y, input bit d,
                                              input logic [23:0] sc, input int n);
        int bx, by, k, fc;
        logic [7:0] rr, gg, bb;
        fc = n % 65536;
        if (!d || x >= H || y >= V) return 24'h0;
        case (md)
            0: return {sc[7:0], sc[15:8], sc[23:16]};
            1: begin
                k = x * 8 / H;
                case (k)
                    0: return 24'hFFFFFF;
                    1: return 24'hFFFF00;
                    2: return 24'h00FFFF;
                    3: return 24'h00FF00;
                    4: return 24'hFF00FF;
                    5: return 24'hFF0000;
                    6: return 24'h0000FF;
                    default: return 24'h000000;
                endcase
            end
            2: begin
                rr = 8'(x % 256);
                return {rr, rr, rr};
            end
            3: return (((x / 32) + (y / 32) + (fc / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
            4: begin
                bx = tri_pos(n, H - 64);
                by = tri_pos(n, V - 64);
                if (x >= bx && x < bx + 64 && y >= by && y < by + 64) return 24'hFFFFFF;
                return 24'h1F1F1F;
            end
            5: return (x % 64 == 0 || y % 64 == 0 || x == H - 1 || y == V - 1) ? 24'hFFFFFF : 24'h0;
            6: begin
                rr = 8'((x + fc) % 256);
                gg = 8'((y + fc) % 256);
                bb = 8'((x % 256) ^ (y % 256));
                return {rr, gg, bb};
            end
            default: return 24'h0;
        endcase
    endfunction

    // One clock: drive inputs, advance the reference, compare the aligned output.
    task automatic step(input bit rs, input bit fs, input bit d, input int x, input int y,
                        input logic [2:0] md);
        logic [24:0] e;
        rst = rs; frame_start = fs; de = d; px = 12'(x); py = 12'(y); mode = md;
        e = {d, model_rgb(m_mode, x, y, d, solid_color, m_n)};
        @(posedge clk);
        if (rs) begin
            m_mode = 0; m_n = 0; exp_d1 = '0; exp_d2 = '0;
        end else begin
            if (fs) begin
                m_mode = int'(md); m_n++;
            end
            exp_d2 = exp_d1;
            exp_d1 = e;
        end
        #1;
        check("pipe", 32'({de_out, r, g, b}), 32'(exp_d2));
        check("mode_active", 32'(mode_active), 32'(m_mode));
        check("frame_cnt", 32'(frame_cnt), 32'(m_n % 65536));
        check("frame_cnt4", 32'(frame_cnt4), 32'(m_n % 16));
    endtask

    task automatic frames(input int k, input logic [2:0] md);
        for (int i = 0; i < k; i++) step(0, 1, 0, 0, 0, md);
    endtask

    task automatic probe(input string nm, input int x, input int y, input logic [2:0] md,
                         input logic [24:0] want);
        step(0, 0, 1, x, y, md);
        step(0, 0, 0, 0, 0, md);
        check(nm, 32'({de_out, r, g, b}), 32'(want));
    endtask

    typedef struct {
        logic [2:0]  md;
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{3'd0, 5, 5, 24'h563412});
        vt.push_back('{3'd1, 159, 0, 24'hFFFFFF});
        vt.push_back('{3'd1, 160, 0, 24'hFFFF00});
        vt.push_back('{3'd1, 800, 3, 24'hFF0000});
        vt.push_back('{3'd1, 1279, 0, 24'h000000});
        vt.push_back('{3'd1, 1280, 0, 24'h000000});
        vt.push_back('{3'd0, 5, 720, 24'h000000});
        vt.push_back('{3'd2, 300, 7, 24'h2C2C2C});
        vt.push_back('{3'd3, 32, 0, 24'hFFFFFF});
        vt.push_back('{3'd3, 0, 0, 24'h000000});
        vt.push_back('{3'd4, 4, 4, 24'hFFFFFF});
        vt.push_back('{3'd4, 3, 4, 24'h1F1F1F});
        vt.push_back('{3'd4, 67, 67, 24'hFFFFFF});
        vt.push_back('{3'd4, 68, 10, 24'h1F1F1F});
        vt.push_back('{3'd5, 64, 3, 24'hFFFFFF});
        vt.push_back('{3'd5, 65, 3, 24'h000000});
        vt.push_back('{3'd5, 1279, 5, 24'hFFFFFF});
        vt.push_back('{3'd5, 5, 719, 24'hFFFFFF});
        vt.push_back('{3'd6, 10, 20, 24'h0B151E});
        vt.push_back('{3'd6, 255, 1, 24'h0002FE});
        vt.push_back('{3'd7, 5, 5, 24'h000000});

        // Reset state and pre-frame behaviour
        solid_color = 24'h0;
        step(1, 0, 0, 0, 0, 3'd2);
        check("reset_rgb", 32'({de_out, r, g, b}), 32'h0);
        check("reset_mode", 32'(mode_active), 32'h0);
        check("reset_cnt", 32'(frame_cnt), 32'h0);
        probe("pre_frame_black", 10, 10, 3'd2, 25'h1_000000);
        frames(1, 3'd2);
        probe("ramp_300", 300, 10, 3'd2, 25'h1_2C2C2C);

        // Constant vector table, each with one frame_start after reset
        solid_color = 24'h123456;
        foreach (vt[i]) begin
            step(1, 0, 0, 0, 0, 3'd0);
            step(0, 1, 0, 0, 0, vt[i].md);
            probe("vec", vt[i].x, vt[i].y, vt[i].md, {1'b1, vt[i].exp});
        end

        // Bar sweep along line 0
        step(1, 0, 0, 0, 0, 3'd0);
        frames(1, 3'd1);
        for (int x = 0; x < H; x++) step(0, 0, 1, x, 0, 3'd1);
        step(0, 0, 0, 0, 0, 3'd1);
        step(0, 0, 0, 0, 0, 3'd1);

        // Mode change without frame_start is ignored; checker inversion
        probe("mode_hold", 0, 0, 3'd3, 25'h1_FFFFFF);
        check("mode_hold_active", 32'(mode_active), 32'd1);
        frames(1, 3'd3);
        probe("chk_0_0", 0, 0, 3'd3, 25'h1_000000);
        probe("chk_32_0", 32, 0, 3'd3, 25'h1_FFFFFF);
        frames(32, 3'd3);
        probe("chk_inverted", 0, 0, 3'd3, 25'h1_FFFFFF);

        // frame_start together with active pixel
        frames(1, 3'd1);
        step(0, 1, 1, 0, 0, 3'd7);
        step(0, 0, 1, 0, 0, 3'd7);
        check("fs_same_old", 32'({de_out, r, g, b}), 32'h1_FFFFFF);
        step(0, 0, 0, 0, 0, 3'd7);
        check("fs_same_new", 32'({de_out, r, g, b}), 32'h1_000000);

        // Reset mid-line overrides frame_start
        step(0, 0, 1, 100, 0, 3'd4);
        step(1, 1, 1, 101, 0, 3'd4);
        check("rst_cnt", 32'(frame_cnt), 32'h0);
        step(0, 0, 1, 102, 0, 3'd4);
        check("rst_flush", 32'({de_out, r, g, b}), 32'h0);
        frames(1, 3'd4);
        probe("box_start_in", 4, 4, 3'd4, 25'h1_FFFFFF);
        probe("box_start_out", 3, 3, 3'd4, 25'h1_1F1F1F);

        // Bouncing box across both turnarounds
        frames(163, 3'd4);
        probe("box164_in", 656, 656, 3'd4, 25'h1_FFFFFF);
        probe("box164_left", 655, 656, 3'd4, 25'h1_1F1F1F);
        probe("box164_top", 656, 655, 3'd4, 25'h1_1F1F1F);
        frames(1, 3'd4);
        probe("box165_in", 660, 652, 3'd4, 25'h1_FFFFFF);
        probe("box165_top", 660, 651, 3'd4, 25'h1_1F1F1F);
        frames(139, 3'd4);
        probe("box304_in", 1216, 96, 3'd4, 25'h1_FFFFFF);
        probe("box304_left", 1215, 96, 3'd4, 25'h1_1F1F1F);
        frames(1, 3'd4);
        probe("box305_in", 1212, 92, 3'd4, 25'h1_FFFFFF);
        probe("box305_left", 1211, 92, 3'd4, 25'h1_1F1F1F);
        probe("box305_far", 1275, 155, 3'd4, 25'h1_FFFFFF);
        probe("box305_past", 1276, 155, 3'd4, 25'h1_1F1F1F);
        check("box305_cnt", 32'(frame_cnt), 32'd305);

        // Narrow frame counter wraps
        step(1, 0, 0, 0, 0, 3'd0);
        frames(15, 3'd0);
        check("cnt4_15", 32'(frame_cnt4), 32'd15);
        frames(1, 3'd0);
        check("cnt4_wrap", 32'(frame_cnt4), 32'd0);
        check("cnt16_16", 32'(frame_cnt), 32'd16);

        // Random stimulus against the reference
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) solid_color = 24'($urandom);
            step($urandom_range(0, 499) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 3) != 0, int'($urandom_range(0, 1300)),
                 int'($urandom_range(0, 730)), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
